// File: rtl/mem_stage.sv
// mem_stage: memory-access stage of the 5-stage RV32I pipeline.
//
// Takes the EX/MEM register outputs, runs the request/grant/response handshake
// to data memory, steers store data onto byte lanes, extracts and extends load
// data, resolves the branch redirect and holds the MEM/WB pipeline register.
// The stage raises stallM while a data-memory access is outstanding.
//
// Optional build macro: MISALIGN_TRAP_EN
//   Defined   : adds output misalignM. A misaligned access issues no bus request,
//               pulses misalignM for one cycle and sends a bubble to WB.
//   Undefined : low address bits are ignored, so the access proceeds as aligned.
//
// Ports
//   clk, rst_n        clock (rising edge), asynchronous active-low reset
//   strCtrlM          funct3 size/sign (000 B, 001 H, 010 W, 100 BU, 101 HU)
//   RegWriteM, MemWriteM, MemtoRegM, rdM   EX/MEM control and destination
//   PCBranchM, branchM, PCplusImmM         branch info -> PCSrcM, PCTargetM
//   ALUoutM, r2M      effective address / ALU result, store data
//   stallM            freezes IF/ID/EX and the EX/MEM register
//   dmem_*            data-memory bus (req/gnt, then rvalid for loads)
//   RegWriteW, MemtoRegW, rdW, ALUoutW, ReadDataW   MEM/WB register
//   misalignM         (MISALIGN_TRAP_EN only) misaligned-access pulse
module mem_stage #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [2:0]      strCtrlM,
    input  logic            RegWriteM,
    input  logic            MemWriteM,
    input  logic            MemtoRegM,
    input  logic            PCBranchM,
    input  logic            branchM,
    input  logic [4:0]      rdM,
    input  logic [XLEN-1:0] ALUoutM,
    input  logic [XLEN-1:0] r2M,
    input  logic [XLEN-1:0] PCplusImmM,
    output logic            PCSrcM,
    output logic [XLEN-1:0] PCTargetM,
    output logic            stallM,
`ifdef MISALIGN_TRAP_EN
    output logic            misalignM,
`endif
    output logic            dmem_req,
    output logic            dmem_we,
    output logic [XLEN-1:0] dmem_addr,
    output logic [XLEN-1:0] dmem_wdata,
    output logic [3:0]      dmem_wstrb,
    input  logic            dmem_gnt,
    input  logic            dmem_rvalid,
    input  logic [XLEN-1:0] dmem_rdata,
    output logic            RegWriteW,
    output logic            MemtoRegW,
    output logic [4:0]      rdW,
    output logic [XLEN-1:0] ALUoutW,
    output logic [XLEN-1:0] ReadDataW
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] REQ  = 2'd1;
    localparam logic [1:0] RESP = 2'd2;
    localparam logic [1:0] DONE = 2'd3;

    logic [1:0]      stateQ, stateD;
    logic            access;
    logic [1:0]      offset;
    logic            isByte, isHalf, isWord;
    logic            trap;
    logic            bubble;
    logic [7:0]      byteLane;
    logic [15:0]     halfLane;
    logic [XLEN-1:0] loadExt;
    logic [XLEN-1:0] loadDataQ;

    assign access = MemWriteM | MemtoRegM;
    assign offset = ALUoutM[1:0];
    assign isByte = (strCtrlM[1:0] == 2'b00);
    assign isHalf = (strCtrlM[1:0] == 2'b01);
    // 010 and the unused codes 011/110/111 all behave as a word access
    assign isWord = ~isByte & ~isHalf;

`ifdef MISALIGN_TRAP_EN
    logic misaligned;
    assign misaligned = (isHalf & offset[0]) | (isWord & (offset != 2'b00));
    assign trap       = (stateQ == IDLE) & access & misaligned;
    assign misalignM  = rst_n & trap;
`else
    assign trap = 1'b0;
`endif

    // ---------------------------------------------------------------- FSM
    always_comb begin
        stateD = stateQ;
        case (stateQ)
            IDLE: if (access && !trap) stateD = REQ;
            REQ:  if (dmem_gnt) stateD = MemWriteM ? DONE : RESP;
            RESP: if (dmem_rvalid) stateD = DONE;
            DONE: stateD = IDLE;
            default: stateD = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) stateQ <= IDLE;
        else        stateQ <= stateD;
    end

    // rst_n gates stallM so that held upstream inputs cannot stall during reset
    assign stallM = rst_n & (((stateQ == IDLE) & access & ~trap) |
                             (stateQ == REQ) | (stateQ == RESP));
    assign bubble = stallM | trap;

    // ---------------------------------------------------------------- bus
    // Address, we, wdata and wstrb derive from M inputs held stable by upstream.
    assign dmem_req  = (stateQ == REQ);
    assign dmem_we   = MemWriteM;
    assign dmem_addr = {ALUoutM[XLEN-1:2], 2'b00};

    always_comb begin
        dmem_wdata = r2M;
        dmem_wstrb = 4'b0000;
        if (MemWriteM) begin
            if (isByte) begin
                dmem_wdata = {4{r2M[7:0]}};
                dmem_wstrb = 4'b0001 << offset;
            end else if (isHalf) begin
                dmem_wdata = {2{r2M[15:0]}};
                dmem_wstrb = 4'b0011 << {offset[1], 1'b0};
            end else begin
                dmem_wstrb = 4'b1111;
            end
        end
    end

    // ---------------------------------------------------------------- load data
    always_comb begin
        case (offset)
            2'd0:    byteLane = dmem_rdata[7:0];
            2'd1:    byteLane = dmem_rdata[15:8];
            2'd2:    byteLane = dmem_rdata[23:16];
            default: byteLane = dmem_rdata[31:24];
        endcase
        halfLane = offset[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];

        if (isByte) begin
            loadExt = strCtrlM[2] ? {{(XLEN-8){1'b0}}, byteLane}
                                  : {{(XLEN-8){byteLane[7]}}, byteLane};
        end else if (isHalf) begin
            loadExt = strCtrlM[2] ? {{(XLEN-16){1'b0}}, halfLane}
                                  : {{(XLEN-16){halfLane[15]}}, halfLane};
        end else begin
            loadExt = dmem_rdata;
        end
    end

    // rvalid only counts in RESP; a stray response in any other state is dropped
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                               loadDataQ <= '0;
        else if ((stateQ == RESP) && dmem_rvalid) loadDataQ <= loadExt;
    end

    // ---------------------------------------------------------------- branch
    assign PCSrcM    = PCBranchM & branchM;
    assign PCTargetM = PCplusImmM;

    // ---------------------------------------------------------------- MEM/WB
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            RegWriteW <= 1'b0;
            MemtoRegW <= 1'b0;
            rdW       <= 5'd0;
            ALUoutW   <= '0;
            ReadDataW <= '0;
        end else if (bubble) begin
            // bubble: control cleared, data registers keep their last value
            RegWriteW <= 1'b0;
            MemtoRegW <= 1'b0;
            rdW       <= 5'd0;
        end else begin
            RegWriteW <= RegWriteM;
            MemtoRegW <= MemtoRegM;
            rdW       <= rdM;
            ALUoutW   <= ALUoutM;
            ReadDataW <= loadDataQ;
        end
    end

endmodule
